// File: rtl/serializer.sv
// Transmit-side framer for the self-test serial link: sends a 1010 header,
// a 32-bit word MSB-first, then GAP_BITS forced-zero bits, one bit per clock.
module serializer #(
    parameter int GAP_BITS = 8
) (
    input  logic        t_clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        ser_out,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [5:0] HEAD_LAST = 6'd3;
    localparam logic [5:0] DATA_LAST = 6'd35;
    localparam logic [4:0] GAP_LAST  = 5'(GAP_BITS - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [35:0] shift_r;
    logic [35:0] shift_nxt_s;
    logic [5:0]  bit_cnt_r;
    logic [5:0]  bit_cnt_nxt_s;
    logic [4:0]  gap_cnt_r;
    logic [4:0]  gap_cnt_nxt_s;
    logic        ser_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;

    assign data_ready = (state_r == IDLE);

    // Next-state and next-output computation for the framer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        ser_nxt_s     = 1'b0;
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (data_valid) begin
                    // The header MSB goes out on the acceptance edge itself.
                    state_nxt_s   = HEAD;
                    shift_nxt_s   = {4'b1010, data_in};
                    ser_nxt_s     = shift_nxt_s[35];
                    bit_cnt_nxt_s = 6'd0;
                    gap_cnt_nxt_s = 5'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HEAD, DATA: begin
                if (bit_cnt_r == DATA_LAST) begin
                    state_nxt_s   = GAP;
                    shift_nxt_s   = 36'd0;
                    gap_cnt_nxt_s = 5'd0;
                end else begin
                    ser_nxt_s     = shift_r[34];
                    shift_nxt_s   = {shift_r[34:0], 1'b0};
                    bit_cnt_nxt_s = bit_cnt_r + 6'd1;
                    if (bit_cnt_r == HEAD_LAST) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s   = IDLE;
                    done_nxt_s    = 1'b1;
                    gap_cnt_nxt_s = 5'd0;
                    bit_cnt_nxt_s = 6'd0;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 5'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= 36'd0;
            bit_cnt_r  <= 6'd0;
            gap_cnt_r  <= 5'd0;
            ser_out    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            gap_cnt_r  <= gap_cnt_nxt_s;
            ser_out    <= ser_nxt_s;
            busy       <= busy_nxt_s;
            frame_done <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: bit-exact frame checks on a GAP_BITS=8
// instance plus a header-hunting receiver model fed by both 8- and 4-gap instances.
module tb_serializer;

    logic        t_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in_a = 32'd0;
    logic        data_valid_a = 1'b0;
    logic        data_ready_a, ser_out_a, busy_a, frame_done_a;
    logic [31:0] data_in_b = 32'd0;
    logic        data_valid_b = 1'b0;
    logic        data_ready_b, ser_out_b, busy_b, frame_done_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [3:0]  rx_win [2];
    logic [31:0] rx_word [2];
    int          rx_n [2];
    bit          rx_lock [2];
    int          rx_cnt [2];

    serializer #(.GAP_BITS(8)) dut_a (
        .t_clk      (t_clk),
        .rst_n      (rst_n),
        .data_in    (data_in_a),
        .data_valid (data_valid_a),
        .data_ready (data_ready_a),
        .ser_out    (ser_out_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    serializer #(.GAP_BITS(4)) dut_b (
        .t_clk      (t_clk),
        .rst_n      (rst_n),
        .data_in    (data_in_b),
        .data_valid (data_valid_b),
        .data_ready (data_ready_b),
        .ser_out    (ser_out_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    always #5 t_clk = ~t_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard push on accepted words and a receiver that hunts for 1010.
    always @(negedge t_clk) begin
        logic        b;
        logic [31:0] w;
        logic [31:0] exp_w;
        int          qsz;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < 2; i++) begin
                rx_win[i]  = 4'd0;
                rx_word[i] = 32'd0;
                rx_n[i]    = 0;
                rx_lock[i] = 1'b0;
                rx_cnt[i]  = 0;
            end
        end else begin
            if (data_valid_a && data_ready_a) qa.push_back(data_in_a);
            if (data_valid_b && data_ready_b) qb.push_back(data_in_b);
            if (frame_done_a) check_eq("done_with_busy_a", busy_a, 1'b0);
            if (frame_done_b) check_eq("done_with_busy_b", busy_b, 1'b0);
            for (int i = 0; i < 2; i++) begin
                b = (i == 0) ? ser_out_a : ser_out_b;
                if (rx_lock[i]) begin
                    w          = {rx_word[i][30:0], b};
                    rx_word[i] = w;
                    rx_n[i]    = rx_n[i] + 1;
                    if (rx_n[i] == 32) begin
                        rx_lock[i] = 1'b0;
                        rx_cnt[i]  = rx_cnt[i] + 1;
                        qsz = (i == 0) ? qa.size() : qb.size();
                        if (qsz == 0) begin
                            check_eq((i == 0) ? "rx_a_queue_len" : "rx_b_queue_len", 64'(qsz), 64'd1);
                        end else begin
                            exp_w = (i == 0) ? qa.pop_front() : qb.pop_front();
                            check_eq((i == 0) ? "rx_a_word" : "rx_b_word", w, exp_w);
                        end
                    end
                end else begin
                    rx_win[i] = {rx_win[i][2:0], b};
                    if (rx_win[i] == 4'b1010) begin
                        rx_lock[i] = 1'b1;
                        rx_n[i]    = 0;
                        rx_win[i]  = 4'd0;
                    end
                end
            end
        end
    end

    // One full frame on instance a with bit-exact checks; tog disturbs inputs mid-DATA.
    task automatic run_frame(input logic [31:0] w, input bit tog);
        logic [35:0] fr;
        int          nbusy;
        fr    = {4'b1010, w};
        nbusy = 0;
        @(posedge t_clk); #1;
        data_in_a    = w;
        data_valid_a = 1'b1;
        @(posedge t_clk); #1;
        data_valid_a = 1'b0;
        for (int k = 0; k <= 45; k++) begin
            @(negedge t_clk);
            if (busy_a) nbusy++;
            if (k < 36)
                check_eq("frame_bit", ser_out_a, fr[35-k]);
            else if (k < 44)
                check_eq("gap_ser_done_ready", {ser_out_a, frame_done_a, data_ready_a}, 3'b000);
            else if (k == 44)
                check_eq("end_ser_busy_done_ready", {ser_out_a, busy_a, frame_done_a, data_ready_a}, 4'b0011);
            else
                check_eq("done_single_pulse", frame_done_a, 1'b0);
            if (tog && k >= 8 && k < 20) begin
                check_eq("ready_low_in_data", data_ready_a, 1'b0);
                #1;
                data_valid_a = k[0];
                data_in_a    = 32'hDEAD_BEEF;
            end else if (tog && k == 20) begin
                #1;
                data_valid_a = 1'b0;
            end
        end
        check_eq("busy_cycles", 64'(nbusy), 64'd44);
    endtask

    // Present a word with valid held; returns just after the accepting edge.
    task automatic send_hold(input bit sel, input logic [31:0] w);
        int t;
        t = 0;
        if (sel) begin
            data_in_b    = w;
            data_valid_b = 1'b1;
        end else begin
            data_in_a    = w;
            data_valid_a = 1'b1;
        end
        while ((sel ? !data_ready_b : !data_ready_a) && t < 200) begin
            @(posedge t_clk); #1;
            t++;
        end
        if (t >= 200) check_eq("send_timeout", 64'(t), 64'd0);
        @(posedge t_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] f1;
        logic [35:0] f2;
        logic        eb;

        // Reset values, then 50 idle cycles.
        repeat (3) @(posedge t_clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge t_clk);
            check_eq("reset_idle", {ser_out_a, busy_a, frame_done_a, data_ready_a}, 4'b0001);
        end

        // Single frame.
        run_frame(32'hA5C3_0F81, 1'b0);

        // Back-to-back with valid held high.
        f1 = {4'b1010, 32'hFFFF_FFFF};
        f2 = {4'b1010, 32'h0000_0000};
        @(posedge t_clk); #1;
        data_in_a    = 32'hFFFF_FFFF;
        data_valid_a = 1'b1;
        @(posedge t_clk); #1;
        data_in_a    = 32'h0000_0000;
        for (int k = 0; k <= 90; k++) begin
            @(negedge t_clk);
            if (k < 36)      eb = f1[35-k];
            else if (k < 45) eb = 1'b0;
            else if (k < 81) eb = f2[80-k];
            else             eb = 1'b0;
            check_eq("b2b_bit", ser_out_a, eb);
            if (k == 44) check_eq("b2b_gap_end_busy_done_ready", {busy_a, frame_done_a, data_ready_a}, 3'b011);
            if (k == 45) begin
                check_eq("b2b_second_accept", {busy_a, data_ready_a}, 2'b10);
                #1 data_valid_a = 1'b0;
            end
            if (k == 89) check_eq("b2b_second_done", {busy_a, frame_done_a}, 2'b01);
        end

        // Ignored inputs during DATA.
        run_frame(32'h1234_5678, 1'b1);

        // Asynchronous reset mid-frame.
        @(posedge t_clk); #1;
        data_in_a    = 32'hAAAA_AAAA;
        data_valid_a = 1'b1;
        @(posedge t_clk); #1;
        data_valid_a = 1'b0;
        repeat (23) @(negedge t_clk);
        check_eq("pre_reset_ser_busy", {ser_out_a, busy_a}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset", {ser_out_a, busy_a, frame_done_a, data_ready_a}, 4'b0001);
        repeat (2) @(posedge t_clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge t_clk);
            check_eq("post_reset_idle", {ser_out_a, busy_a, frame_done_a, data_ready_a}, 4'b0001);
        end
        run_frame(32'h0000_00FF, 1'b0);

        // Loopback into the receiver model at both gap lengths.
        @(posedge t_clk); #1;
        fork
            begin
                send_hold(1'b0, 32'h0102_0304);
                send_hold(1'b0, 32'h0A0A_0A0A);
                data_valid_a = 1'b0;
            end
            begin
                send_hold(1'b1, 32'h0102_0304);
                send_hold(1'b1, 32'h0A0A_0A0A);
                data_valid_b = 1'b0;
            end
        join
        for (int t = 0; t < 300 && (qa.size() != 0 || qb.size() != 0 || busy_a || busy_b); t++)
            @(posedge t_clk);
        repeat (4) @(posedge t_clk);
        @(negedge t_clk);
        check_eq("rx_a_pending", 64'(qa.size()), 64'd0);
        check_eq("rx_b_pending", 64'(qb.size()), 64'd0);
        check_eq("rx_a_frames", 64'(rx_cnt[0]), 64'd3);
        check_eq("rx_b_frames", 64'(rx_cnt[1]), 64'd2);
        check_eq("rx_a_unlocked", rx_lock[0], 1'b0);
        check_eq("rx_b_unlocked", rx_lock[1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serializer.md
# serializer

Transmit-side framer for the self-test serial link. Accepts a 32-bit word over a valid/ready handshake and shifts it out one bit per clock on a single line. Each frame is a 4-bit `1010` header, then 32 data bits MSB-first (byte 3 first), then a run of forced-zero gap bits. It drives the link consumed by the receive-side deserializer, which hunts for the `1010` header and rebuilds the four bytes.

## Interface

Parameters:
- `GAP_BITS`, default 8: number of forced-zero bit times after each frame. Legal range 4..31. The minimum of 4 clears the receiver's 4-bit header window.

Ports:
- `t_clk` input 1: link clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `data_in` input 32: word to transmit; sampled only on the acceptance edge.
- `data_valid` input 1: `data_in` is presented.
- `data_ready` output 1: block can accept a word; high only in IDLE.
- `ser_out` output 1: serial bit stream, registered.
- `busy` output 1: frame in progress (HEAD, DATA or GAP); registered.
- `frame_done` output 1: one-cycle pulse when a frame, including its gap, completes.

## Operation

- States:
  - IDLE: `ser_out`=0, `data_ready`=1.
  - HEAD: 4 header bits.
  - DATA: 32 data bits.
  - GAP: `GAP_BITS` zero bits.
- Acceptance: a rising edge with `data_valid`=1 and state IDLE. On that edge:
  - a 36-bit shift register loads {4'b1010, `data_in`};
  - `ser_out` takes the register MSB, which is 1;
  - the bit counter resets;
  - state becomes HEAD.
- HEAD to DATA after 4 header bits; DATA to GAP after 32 data bits. One 6-bit counter runs 0..35 across HEAD and DATA. A 5-bit counter handles GAP.
- Shift: each edge in HEAD/DATA, `ser_out` <= next MSB and the shift register moves left by 1.
- GAP: `ser_out` forced to 0. After `GAP_BITS` bits, state goes to IDLE and `frame_done` pulses for one cycle.
- `data_ready` is combinational: state == IDLE. `data_valid` is ignored outside IDLE, and `data_in` changes after acceptance have no effect.
- `busy` = 1 from the acceptance edge until the edge that returns the block to IDLE.
- Reset, at any time and including mid-frame, immediately forces:
  - state IDLE;
  - `ser_out`=0, `busy`=0, `frame_done`=0, `data_ready`=1;
  - shift register and counters to 0.
  
  No partial frame resumes after reset.

## Timing

Let A be the acceptance edge. "After edge X" means the value during the cycle that follows edge X.

- Header bits 1,0,1,0: on `ser_out` after edges A..A+3.
- Data bit 31-k: on `ser_out` after edge A+4+k, for k=0..31. `data_in[31]` appears after A+4 and `data_in[0]` after A+35.
- Gap zeros: after edges A+36..A+35+`GAP_BITS`.
- Edge A+36+`GAP_BITS`:
  - state goes to IDLE;
  - `frame_done`=1 and `data_ready`=1 for the following cycle;
  - `busy`=0.
- Back-to-back:
  - earliest next acceptance edge is A+37+`GAP_BITS`;
  - minimum frame period is 37+`GAP_BITS` cycles (45 at default);
  - `ser_out` is 0 for exactly `GAP_BITS`+1 cycles between frames when `data_valid` is held high.
- `frame_done` never coincides with `busy`=1.
- Latency from acceptance to first header bit is 0 cycles: registered on edge A itself.

## Test plan

1. **Reset values.** Assert `rst_n`=0 for 3 cycles, then release. Required: `ser_out`=0, `busy`=0, `frame_done`=0, `data_ready`=1, held steady with `data_valid`=0 for 50 cycles.
2. **Single frame.** `data_in`=32'hA5C3_0F81, one-cycle `data_valid`. Required after edges A..A+35: `ser_out` = 1010 then 1010_0101_1100_0011_0000_1111_1000_0001. Then 8 zeros, `frame_done` pulse after edge A+44, `busy` high for exactly 44 cycles.
3. **Back-to-back.** `data_valid` held high with words 32'hFFFF_FFFF then 32'h0000_0000. Required: second acceptance at A+45, exactly 9 zero cycles between the last 1 of frame 1 and the header of frame 2, second frame payload all zeros.
4. **Ignored inputs.** During DATA of frame 32'h1234_5678, toggle `data_valid` and change `data_in` to 32'hDEAD_BEEF. Required: transmitted payload remains 32'h1234_5678, and no extra acceptance occurs before `frame_done`.
5. **Reset mid-frame.** Assert `rst_n` low at bit 20 of frame 32'hAAAA_AAAA. Required: `ser_out`=0 and `busy`=0 immediately, without waiting for a clock edge. After release, the next word 32'h0000_00FF is sent as a complete, correctly ordered frame.
6. **Loopback.** Drive `ser_out` into the deserializer with `GAP_BITS`=4 and 8. Send words 32'h0102_0304 and 32'h0A0A_0A0A, a payload containing the header pattern. Required: the receiver recovers every frame with no false header lock inside data or gap bits.
